// File: rtl/pistorm_pkg.sv
// Shared definitions for the PiStorm bus logic: arbiter state encodings,
// status-register field width and the default grant timeout.
package pistorm_pkg;

    localparam int ARB_STATE_W = 3;

    localparam logic [9:0] GRANT_TIMEOUT_DEFAULT = 10'd1000;

    // Encodings are visible to the Pi through arb_state, so they are fixed.
    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE     = 3'd0,
        ARB_REQ      = 3'd1,
        ARB_WAIT_BUS = 3'd2,
        ARB_OWN      = 3'd3,
        ARB_RELEASE  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// 68000 bus-mastership arbiter: requests the bus with nBR, takes it with nBGACK
// once the current master has finished, and hands it back on request drop.
module bus_arbiter
    import pistorm_pkg::*;
#(
    parameter logic [9:0] GRANT_TIMEOUT = GRANT_TIMEOUT_DEFAULT
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset,
    input  logic                   mc_clk_rising,
    input  logic                   mc_clk_falling,
    input  logic                   req_pi,
    input  logic                   req_hold,
    input  logic                   cycle_busy,
    input  logic                   bg_n,
    input  logic                   as_n,
    input  logic                   dtack_n,
    input  logic                   bgack_n,
    input  logic                   bus_reset_n,
    output logic                   br_drive,
    output logic                   bgack_drive,
    output logic                   grant,
    output logic                   arb_timeout,
    output logic [ARB_STATE_W-1:0] arb_state
);

    arb_state_e state_reg, state_next;
    logic [9:0] count_reg, count_next;
    logic       br_reg, br_next;
    logic       bgack_reg, bgack_next;
    logic       timeout_reg, timeout_next;
    logic       bus_free;

    // The previous master is gone only when AS, DTACK and BGACK are all negated.
    assign bus_free = as_n & dtack_n & bgack_n;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_reg   <= ARB_IDLE;
            count_reg   <= '0;
            br_reg      <= 1'b0;
            bgack_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            br_reg      <= br_next;
            bgack_reg   <= bgack_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        br_next      = br_reg;
        bgack_next   = bgack_reg;
        timeout_next = 1'b0;

        if (!bus_reset_n) begin
            // A 68000 bus reset drops everything immediately, even mid-cycle.
            state_next = ARB_IDLE;
            count_next = '0;
            br_next    = 1'b0;
            bgack_next = 1'b0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    count_next = '0;
                    if (req_pi) begin
                        br_next    = 1'b1;
                        state_next = ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (!req_pi) begin
                        br_next    = 1'b0;
                        state_next = ARB_IDLE;
                    end else if (mc_clk_falling) begin
                        // A grant seen on the final strobe still wins over the timeout.
                        if (!bg_n) begin
                            state_next = ARB_WAIT_BUS;
                        end else if (count_reg == GRANT_TIMEOUT - 10'd1) begin
                            br_next      = 1'b0;
                            timeout_next = 1'b1;
                            state_next   = ARB_IDLE;
                        end else begin
                            count_next = count_reg + 10'd1;
                        end
                    end
                end
                ARB_WAIT_BUS: begin
                    if (mc_clk_falling && bus_free) begin
                        bgack_next = 1'b1;
                        br_next    = 1'b0;
                        state_next = ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (!req_pi && !req_hold) begin
                        state_next = ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    if (!cycle_busy && mc_clk_rising) begin
                        bgack_next = 1'b0;
                        state_next = ARB_IDLE;
                    end
                end
                default: begin
                    state_next = ARB_IDLE;
                    count_next = '0;
                    br_next    = 1'b0;
                    bgack_next = 1'b0;
                end
            endcase
        end
    end

    assign br_drive    = br_reg;
    assign bgack_drive = bgack_reg;
    assign arb_timeout = timeout_reg;
    assign grant       = (state_reg == ARB_OWN);
    assign arb_state   = state_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a behavioural model
// of the bus-ownership phases.
module tb_bus_arbiter;

    localparam int TIMEOUT_FALLS = 8;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_OWN = 3, PH_REL = 4;

    logic       sys_clk = 1'b0;
    logic       sys_reset, mc_clk_rising, mc_clk_falling;
    logic       req_pi, req_hold, cycle_busy;
    logic       bg_n, as_n, dtack_n, bgack_n, bus_reset_n;
    logic       br_drive, bgack_drive, grant, arb_timeout;
    logic [2:0] arb_state;

    int total = 0;
    int bad   = 0;
    int tick  = 0;

    // Model: current ownership phase, falling edges waited for BG, timeout pulse.
    int phase      = PH_IDLE;
    int falls_seen = 0;
    bit tout_exp   = 1'b0;

    bus_arbiter #(.GRANT_TIMEOUT(10'd8)) dut (
        .sys_clk       (sys_clk),
        .sys_reset     (sys_reset),
        .mc_clk_rising (mc_clk_rising),
        .mc_clk_falling(mc_clk_falling),
        .req_pi        (req_pi),
        .req_hold      (req_hold),
        .cycle_busy    (cycle_busy),
        .bg_n          (bg_n),
        .as_n          (as_n),
        .dtack_n       (dtack_n),
        .bgack_n       (bgack_n),
        .bus_reset_n   (bus_reset_n),
        .br_drive      (br_drive),
        .bgack_drive   (bgack_drive),
        .grant         (grant),
        .arb_timeout   (arb_timeout),
        .arb_state     (arb_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        tout_exp = 1'b0;
        if (sys_reset) begin
            phase = PH_IDLE;
            falls_seen = 0;
        end else if (!bus_reset_n) begin
            phase = PH_IDLE;
        end else begin
            case (phase)
                PH_IDLE: if (req_pi) begin
                    phase = PH_REQ;
                    falls_seen = 0;
                end
                PH_REQ: if (!req_pi) phase = PH_IDLE;
                    else if (mc_clk_falling) begin
                        if (!bg_n) phase = PH_WAIT;
                        else begin
                            falls_seen++;
                            if (falls_seen == TIMEOUT_FALLS) begin
                                tout_exp = 1'b1;
                                phase = PH_IDLE;
                            end
                        end
                    end
                PH_WAIT: if (mc_clk_falling && as_n && dtack_n && bgack_n) phase = PH_OWN;
                PH_OWN:  if (!req_pi && !req_hold) phase = PH_REL;
                PH_REL:  if (!cycle_busy && mc_clk_rising) phase = PH_IDLE;
                default: phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        chk("arb_state",   32'(arb_state),   32'(phase));
        chk("br_drive",    32'(br_drive),    32'(phase == PH_REQ || phase == PH_WAIT));
        chk("bgack_drive", 32'(bgack_drive), 32'(phase == PH_OWN || phase == PH_REL));
        chk("grant",       32'(grant),       32'(phase == PH_OWN));
        chk("arb_timeout", 32'(arb_timeout), 32'(tout_exp));
    endtask

    // One sys_clk: CLK_7M is modelled as 8 sys_clks, rising at 0, falling at 4.
    task automatic step();
        mc_clk_rising  = (tick % 8 == 0);
        mc_clk_falling = (tick % 8 == 4);
        @(posedge sys_clk);
        model_update();
        tick++;
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int pulses;

    initial begin
        sys_reset = 1'b1; req_pi = 1'b0; req_hold = 1'b0; cycle_busy = 1'b0;
        bg_n = 1'b1; as_n = 1'b1; dtack_n = 1'b1; bgack_n = 1'b1; bus_reset_n = 1'b1;
        mc_clk_rising = 1'b0; mc_clk_falling = 1'b0;

        steps(2);
        chk("reset_state", 32'(arb_state), 32'd0);
        chk("reset_outs",  32'({br_drive, bgack_drive, grant, arb_timeout}), 32'd0);
        sys_reset = 1'b0;
        steps(3);
        $display("txn reset: arb_state=%0d", arb_state);

        // Normal grant with an idle bus.
        req_pi = 1'b1;
        steps(16);
        chk("req_state", 32'(arb_state), 32'd1);
        chk("req_br",    32'(br_drive),  32'd1);
        bg_n = 1'b0;
        steps(16);
        chk("grant_state", 32'(arb_state), 32'd3);
        chk("grant_out",   32'({br_drive, bgack_drive, grant}), 32'b011);
        $display("txn grant: arb_state=%0d grant=%0d", arb_state, grant);

        // Release while a cycle is still in flight.
        cycle_busy = 1'b1;
        req_pi = 1'b0;
        step();
        chk("rel_grant_drop", 32'(grant), 32'd0);
        steps(20);
        chk("rel_bgack_held", 32'(bgack_drive), 32'd1);
        cycle_busy = 1'b0;
        steps(8);
        chk("rel_done", 32'(arb_state), 32'd0);
        $display("txn release: bgack_drive=%0d", bgack_drive);

        // Bus busy: stay in WAIT_BUS until the previous master negates AS.
        as_n = 1'b0; bg_n = 1'b0; req_pi = 1'b1;
        steps(40);
        chk("busy_wait", 32'(arb_state), 32'd2);
        chk("busy_grant", 32'(grant), 32'd0);
        as_n = 1'b1;
        steps(8);
        chk("busy_own", 32'(arb_state), 32'd3);
        $display("txn bus_busy: arb_state=%0d", arb_state);

        // Lock: req_hold keeps ownership after req_pi drops.
        req_hold = 1'b1; req_pi = 1'b0;
        steps(16);
        chk("lock_grant", 32'(grant), 32'd1);
        req_hold = 1'b0;
        step();
        chk("lock_release", 32'(arb_state), 32'd4);
        steps(8);
        $display("txn lock: arb_state=%0d", arb_state);

        // Bus reset while owning the bus mid-cycle.
        req_pi = 1'b1;
        steps(24);
        chk("brst_pre_own", 32'(arb_state), 32'd3);
        cycle_busy = 1'b1; bus_reset_n = 1'b0;
        step();
        chk("brst_state", 32'(arb_state), 32'd0);
        chk("brst_outs",  32'({br_drive, bgack_drive, grant, arb_timeout}), 32'd0);
        bus_reset_n = 1'b1; req_pi = 1'b0; cycle_busy = 1'b0;
        steps(4);
        $display("txn bus_reset: arb_state=%0d", arb_state);

        // Timeout: BG never arrives; exactly one pulse within nine CLK_7M cycles.
        bg_n = 1'b1; req_pi = 1'b1;
        pulses = 0;
        for (int i = 0; i < 72; i++) begin
            step();
            if (arb_timeout === 1'b1) begin
                pulses++;
                chk("tout_br",    32'(br_drive),  32'd0);
                chk("tout_state", 32'(arb_state), 32'd0);
            end
        end
        chk("tout_pulses", 32'(pulses), 32'd1);
        req_pi = 1'b0;
        steps(2);
        $display("txn timeout: pulses=%0d", pulses);

        // Randomized traffic.
        pulses = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) req_pi = ~req_pi;
            if ($urandom_range(15) == 0) req_hold = ~req_hold;
            if ($urandom_range(3) == 0)  cycle_busy = ~cycle_busy;
            if ($urandom_range(19) == 0) bg_n = ~bg_n;
            as_n        = ($urandom_range(3) != 0);
            dtack_n     = ($urandom_range(7) != 0);
            bgack_n     = ($urandom_range(7) != 0);
            bus_reset_n = ($urandom_range(199) != 0);
            sys_reset   = ($urandom_range(499) == 0);
            step();
            if (arb_timeout === 1'b1) pulses++;
        end
        $display("txn random: cycles=4000 timeouts=%0d", pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
